// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall controller: load-use stalls, ID branch flushes, MDU EX holds, stall counter.
// Latency: all control outputs are combinational from state/cnt/inputs; stall counter lags by 1 cycle.
// Backpressure: freezes the front end for MDU_CYCLES-1 cycles per MDU op and 1 cycle per load-use hazard.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_if_id_rs, i_if_id_rt    source registers of the instruction in ID
//   i_id_ex_mem_read          instruction in EX is a load
//   i_id_ex_rt                destination register of that load
//   i_branch_taken            branch in ID resolved taken this cycle
//   i_mdu_start               one-cycle pulse, MDU op just entered EX
//   o_pc_write, o_if_id_write enable PC / IF-ID update
//   o_if_id_flush             zero IF/ID on the next edge
//   o_id_ex_bubble            load zeroed controls into ID/EX
//   o_id_ex_hold              ID/EX keeps its contents
//   o_ex_mem_bubble           load zeroed controls into EX/MEM
//   o_mdu_busy                an MDU op occupies EX
//   o_stall_count             saturating count of cycles with PC write disabled
module hazard_sequencer #(
  parameter int MDU_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_if_id_rs,
  input  logic [4:0]  i_if_id_rt,
  input  logic        i_id_ex_mem_read,
  input  logic [4:0]  i_id_ex_rt,
  input  logic        i_branch_taken,
  input  logic        i_mdu_start,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_if_id_flush,
  output logic        o_id_ex_bubble,
  output logic        o_id_ex_hold,
  output logic        o_ex_mem_bubble,
  output logic        o_mdu_busy,
  output logic [15:0] o_stall_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // The start cycle is itself a freeze cycle, so the wait state only needs
  // MDU_CYCLES-2 further freeze cycles before the release cycle.
  localparam logic [7:0] CNT_INIT = 8'(MDU_CYCLES - 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] r_stall_count;

  logic w_freeze;
  logic w_load_use;

  always_comb begin
    w_freeze        = 1'b0;
    w_load_use      = 1'b0;
    o_pc_write      = 1'b1;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_bubble  = 1'b0;
    o_id_ex_hold    = 1'b0;
    o_ex_mem_bubble = 1'b0;
    o_mdu_busy      = 1'b0;
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;

    // Reset forces RUN defaults on the outputs regardless of state or inputs.
    if (!i_rst) begin
      w_freeze = ((r_state == RUN) && i_mdu_start) ||
                 ((r_state == MDU_WAIT) && (r_cnt != 8'd0));

      // Register 0 is hardwired, so a load into it never creates a hazard.
      w_load_use = !w_freeze && i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                   ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

      o_mdu_busy = ((r_state == RUN) && i_mdu_start) || (r_state == MDU_WAIT);

      if (w_freeze) begin
        o_pc_write      = 1'b0;
        o_if_id_write   = 1'b0;
        o_id_ex_hold    = 1'b1;
        o_ex_mem_bubble = 1'b1;
      end else if (w_load_use) begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
      end else if (i_branch_taken) begin
        // A stalled branch stays in ID and re-resolves, so the flush is only
        // issued on a cycle where the front end actually advances.
        o_if_id_flush = 1'b1;
      end

      case (r_state)
        RUN: begin
          if (i_mdu_start) begin
            w_state_nxt = MDU_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
        MDU_WAIT: begin
          // mdu_start is ignored here, including in the release cycle.
          if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_cnt         <= 8'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!o_pc_write && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign o_stall_count = r_stall_count;

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall controller for the five-stage core. Sits beside the forwarding unit and decides, every cycle, whether the front end (PC, IF/ID) advances, stalls or flushes. It handles three cases: load-use hazards, taken-branch flushes resolved in ID, and multi-cycle multiply/divide (MDU) operations that hold EX for several cycles. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MDU_CYCLES, 4, total cycles an MDU op occupies EX; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- IF_ID_Rs  input  5  source register 1 of the instruction in ID.
- IF_ID_Rt  input  5  source register 2 of the instruction in ID.
- ID_EX_mem_read  input  1  instruction in EX is a load.
- ID_EX_Rt  input  5  destination of the load in EX.
- branch_taken  input  1  branch in ID resolved taken this cycle.
- mdu_start  input  1  one-cycle pulse: an MDU op has just entered EX.
- PC_write  output  1  PC may update.
- IF_ID_write  output  1  IF/ID may load.
- IF_ID_flush  output  1  zero IF/ID on the next edge.
- ID_EX_bubble  output  1  load zeroed controls into ID/EX.
- ID_EX_hold  output  1  ID/EX keeps its contents.
- EX_MEM_bubble  output  1  load zeroed controls into EX/MEM.
- mdu_busy  output  1  an MDU op is occupying EX.
- stall_count  output  16  number of cycles with PC_write=0; saturating.

## Operation
- State register: RUN, MDU_WAIT. Down-counter cnt is 8 bits wide.
- All outputs are combinational functions of state, cnt and the inputs. stall_count is a registered value.
- freeze is asserted in two cases: (RUN and mdu_start), or (MDU_WAIT and cnt != 0).
- While freeze is asserted:
  - PC_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_bubble=1.
  - ID_EX_bubble=0, IF_ID_flush=0.
- load_use = ID_EX_mem_read && ID_EX_Rt != 0 && (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt).
  - Evaluated only when freeze=0.
  - When true: PC_write=0, IF_ID_write=0, ID_EX_bubble=1.
- Flush: IF_ID_flush = branch_taken && !freeze && !load_use. A branch that is stalled stays in ID and re-resolves after the stall.
- Default (no freeze, no load_use): PC_write=1, IF_ID_write=1, all bubble/hold/flush outputs 0.
- Transitions:
  - RUN with mdu_start goes to MDU_WAIT and loads cnt = MDU_CYCLES-2.
  - MDU_WAIT with cnt != 0 stays in MDU_WAIT and decrements cnt.
  - MDU_WAIT with cnt == 0 is the release cycle: freeze=0 and next state is RUN.
- mdu_start is ignored in MDU_WAIT, including the release cycle.
- mdu_busy = (RUN && mdu_start) || MDU_WAIT.
- stall_count increments each cycle PC_write=0 and holds at 16'hFFFF.
- Priority: freeze > load_use > branch flush.

## Timing
- Reset: on the clk edge with rst=1, state becomes RUN, cnt=0, stall_count=0.
- While rst=1, outputs are forced regardless of inputs: PC_write=1, IF_ID_write=1, all bubble/hold/flush outputs 0, mdu_busy=0.
- Reset asserted during MDU_WAIT aborts the wait; outputs are RUN defaults from the next cycle.
- Load-use stall lasts exactly 1 cycle. No state is needed: the next cycle ID/EX holds the bubble, so the hazard cannot retrigger.
- MDU sequence:
  - freeze is asserted for MDU_CYCLES-1 consecutive cycles, starting in the mdu_start cycle.
  - Release cycle is MDU_CYCLES-1 cycles after mdu_start.
  - Back in RUN MDU_CYCLES cycles after mdu_start.
  - MDU_CYCLES=2: a single freeze cycle, then the release cycle with cnt=0.
- Release cycle: load_use and branch_taken are evaluated as in RUN.
- Simultaneous mdu_start and branch_taken in RUN: freeze only; the flush is deferred to the release cycle.
- Simultaneous load_use and branch_taken: stall only, IF_ID_flush=0.
- stall_count updates on the edge ending each PC_write=0 cycle, so it is visible 1 cycle later.

## Test plan
- Reset check: rst=1 for 2 cycles with random inputs -> PC_write=1, IF_ID_write=1, all bubble/hold/flush outputs 0, stall_count=0.
- Load-use:
  - ID_EX_mem_read=1, ID_EX_Rt=5, IF_ID_Rt=5 for 1 cycle -> PC_write=0, ID_EX_bubble=1 that cycle; stall_count=1 next cycle.
  - Repeat with ID_EX_Rt=0 -> no stall.
- MDU, MDU_CYCLES=4:
  - mdu_start pulse at cycle t -> freeze at t, t+1, t+2; release at t+3 with PC_write=1; RUN at t+4.
  - mdu_busy is high t..t+3; stall_count rises by 3.
- MDU combined with branch: mdu_start and branch_taken at t, branch_taken held -> IF_ID_flush=0 at t..t+2, IF_ID_flush=1 at t+3.
- Load-use and branch together: load_use with branch_taken=1 -> IF_ID_flush=0, ID_EX_bubble=1. Next cycle, branch_taken=1 alone -> IF_ID_flush=1.
- Abort and saturation:
  - rst asserted at t+1 of an MDU_CYCLES=4 op -> RUN defaults from t+2; a new mdu_start at t+3 is accepted.
  - Forced freeze for 70000 cycles -> stall_count holds at 16'hFFFF.
